comet_ib_fill: RTL and testbench

Instruction-buffer fill controller for the COMET memory interface. It issues longword prefetch requests whenever an 8-byte byte queue has room, and steps the prefetch address in the address slice by 4 on each accepted fill. It presents a little-endian 4-byte window to the instruction decoder and retires 0–4 bytes per cycle. It is the consuming end of the address slice's PC/prefetch path: it decides when the PC advances and absorbs the data fetched at that PC.

---
 rtl/comet_ib_fill_if.sv | 11 +
 rtl/comet_ib_fill.sv | 106 ++++++++++
 tb/tb_comet_ib_fill.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/comet_ib_fill_if.sv
// Fetch-side handshake between the instruction-buffer fill controller and
// the memory/address-slice side: request/ack, fetched longword, PC step pulse.
interface comet_ib_fill_if;
    logic        ib_req_h;
    logic        ib_ack_h;
    logic [31:0] mem_data_h;
    logic        pc_inc4_h;

    modport master (output ib_req_h, output pc_inc4_h, input ib_ack_h, input mem_data_h);
    modport slave  (input ib_req_h, input pc_inc4_h, output ib_ack_h, output mem_data_h);
endinterface

// File: rtl/comet_ib_fill.sv
// COMET instruction-buffer fill controller: 8-byte byte queue, longword
// prefetch with one outstanding fetch, 0-4 bytes retired per cycle.
module comet_ib_fill (
    input  logic                   b_clk_l,
    input  logic                   reset_h,
    comet_ib_fill_if.master        mem,
    input  logic                   flush_h,
    input  logic [1:0]             start_ofs_h,
    output logic [31:0]            ib_data_h,
    output logic [3:0]             ib_count_h,
    input  logic [2:0]             consume_h,
    output logic                   ib_err_h
);
    typedef enum logic [1:0] {IDLE, FETCH, STALE} state_t;

    state_t          state;
    logic            req;
    logic            err;
    logic [7:0][7:0] q, q_nxt;
    logic [3:0]      count, count_nxt, base;
    logic [1:0]      skip;
    logic            legal, room, accept;
    logic [2:0]      cons_eff;

    always_comb begin
        legal    = (consume_h <= 3'd4) && ({1'b0, consume_h} <= count);
        cons_eff = legal ? consume_h : 3'd0;
        base     = count - {1'b0, cons_eff};
        room     = (base <= 4'd4);
        accept   = (state == FETCH) && mem.ib_ack_h && !flush_h && !reset_h;
    end

    // Queue bytes at or beyond count are kept zero, so the window needs no masking.
    always_comb begin
        q_nxt     = q >> {cons_eff, 3'b000};
        count_nxt = base;
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= int'(skip))
                    q_nxt[base[2:0] + 3'(i) - 3'(skip)] = mem.mem_data_h[8*i +: 8];
            end
            count_nxt = base + 4'd4 - {2'b00, skip};
        end
    end

    always_ff @(posedge b_clk_l) begin
        if (reset_h) begin
            state <= IDLE;
            req   <= 1'b0;
            err   <= 1'b0;
            q     <= '0;
            count <= 4'd0;
            skip  <= 2'd0;
        end else if (flush_h) begin
            q     <= '0;
            count <= 4'd0;
            err   <= 1'b0;
            skip  <= start_ofs_h;
            // An in-flight fetch now targets the old PC; its data must be dropped.
            case (state)
                IDLE: ;
                FETCH, STALE: begin
                    if (mem.ib_ack_h) begin
                        state <= IDLE;
                        req   <= 1'b0;
                    end else begin
                        state <= STALE;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end else begin
            q     <= q_nxt;
            count <= count_nxt;
            if (!legal) err <= 1'b1;
            if (accept) skip <= 2'd0;
            case (state)
                IDLE: begin
                    if (room) begin
                        state <= FETCH;
                        req   <= 1'b1;
                    end
                end
                FETCH, STALE: begin
                    if (mem.ib_ack_h) begin
                        state <= IDLE;
                        req   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    assign mem.ib_req_h  = req;
    assign mem.pc_inc4_h = accept;
    assign ib_data_h     = q[3:0];
    assign ib_count_h    = count;
    assign ib_err_h      = err;
endmodule

// File: tb/tb_comet_ib_fill.sv
// Bench for comet_ib_fill: byte-queue model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_comet_ib_fill;
    logic        b_clk_l = 1'b0;
    logic        reset_h = 1'b1;
    logic        flush_h = 1'b0;
    logic [1:0]  start_ofs_h = 2'd0;
    logic [2:0]  consume_h = 3'd0;
    logic [31:0] ib_data_h;
    logic [3:0]  ib_count_h;
    logic        ib_err_h;

    comet_ib_fill_if bus ();

    comet_ib_fill dut (
        .b_clk_l     (b_clk_l),
        .reset_h     (reset_h),
        .mem         (bus),
        .flush_h     (flush_h),
        .start_ofs_h (start_ofs_h),
        .ib_data_h   (ib_data_h),
        .ib_count_h  (ib_count_h),
        .consume_h   (consume_h),
        .ib_err_h    (ib_err_h)
    );

    always #5 b_clk_l = ~b_clk_l;

    int checks = 0;
    int errors = 0;
    int inc_cnt = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a byte queue, one outstanding-fetch flag, and a flag saying the
    // outstanding fetch was orphaned by a redirect.
    byte unsigned mq[$];
    bit           m_out = 0, m_stale = 0, m_err = 0;
    int           m_skip = 0;

    always @(posedge b_clk_l) begin
        byte unsigned t;
        if (reset_h) begin
            mq.delete();
            m_out = 0; m_stale = 0; m_skip = 0; m_err = 0;
        end else if (flush_h) begin
            mq.delete();
            m_err  = 0;
            m_skip = int'(start_ofs_h);
            if (m_out) begin
                if (bus.ib_ack_h) begin m_out = 0; m_stale = 0; end
                else m_stale = 1;
            end
        end else begin
            if (int'(consume_h) > 4 || int'(consume_h) > mq.size()) m_err = 1;
            else repeat (int'(consume_h)) t = mq.pop_front();
            if (m_out && bus.ib_ack_h) begin
                if (!m_stale) begin
                    for (int i = m_skip; i < 4; i++) mq.push_back(bus.mem_data_h[8*i +: 8]);
                    m_skip = 0;
                end
                m_out = 0; m_stale = 0;
            end else if (!m_out && mq.size() <= 4) begin
                m_out = 1;
            end
        end
    end

    always @(negedge b_clk_l) begin
        logic [31:0] exp_data;
        logic        exp_inc;
        if (chk_en) begin
            exp_inc  = m_out && !m_stale && bus.ib_ack_h && !flush_h && !reset_h;
            exp_data = '0;
            for (int i = 0; i < 4; i++)
                if (i < mq.size()) exp_data[8*i +: 8] = mq[i];
            chk("m_req",   {31'd0, bus.ib_req_h},  {31'd0, m_out});
            chk("m_inc4",  {31'd0, bus.pc_inc4_h}, {31'd0, exp_inc});
            chk("m_count", {28'd0, ib_count_h},    32'(mq.size()));
            chk("m_data",  ib_data_h,              exp_data);
            chk("m_err",   {31'd0, ib_err_h},      {31'd0, m_err});
            if (bus.pc_inc4_h) inc_cnt++;
        end
    end

    task automatic cyc(input bit fl, input logic [1:0] ofs, input bit ack,
                       input logic [31:0] d, input logic [2:0] c);
        flush_h = fl; start_ofs_h = ofs; bus.ib_ack_h = ack; bus.mem_data_h = d; consume_h = c;
        @(posedge b_clk_l);
        #1;
        flush_h = 0; start_ofs_h = 0; bus.ib_ack_h = 0; bus.mem_data_h = 0; consume_h = 0;
    endtask

    task automatic idle();
        cyc(0, 2'd0, 0, 32'd0, 3'd0);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.ib_req_h && n < 8) begin idle(); n++; end
        chk("wait_req", {31'd0, bus.ib_req_h}, 32'd1);
    endtask

    task automatic lit(input string nm, input logic [3:0] cnt, input logic [31:0] data,
                       input bit req, input bit err, input int incs);
        chk({nm, "_count"}, {28'd0, ib_count_h}, {28'd0, cnt});
        chk({nm, "_data"},  ib_data_h, data);
        chk({nm, "_req"},   {31'd0, bus.ib_req_h}, {31'd0, req});
        chk({nm, "_err"},   {31'd0, ib_err_h}, {31'd0, err});
        chk({nm, "_incs"},  32'(inc_cnt), 32'(incs));
    endtask

    initial begin
        bus.ib_ack_h = 0; bus.mem_data_h = 0;
        // Reset, then first fetch from empty queue
        idle();
        chk_en = 1;
        idle();
        reset_h = 0;
        lit("reset", 4'd0, 32'h0, 0, 0, 0);
        idle();
        lit("first_req", 4'd0, 32'h0, 1, 0, 0);
        idle();
        cyc(0, 2'd0, 1, 32'h44332211, 3'd0);
        lit("fill1", 4'd4, 32'h44332211, 0, 0, 1);
        idle();
        lit("req2", 4'd4, 32'h44332211, 1, 0, 1);
        cyc(0, 2'd0, 1, 32'h88776655, 3'd0);
        lit("fill2", 4'd8, 32'h44332211, 0, 0, 2);
        idle(); idle(); idle();
        lit("full_noreq", 4'd8, 32'h44332211, 0, 0, 2);
        cyc(0, 2'd0, 0, 32'd0, 3'd5);
        lit("cons5", 4'd8, 32'h44332211, 0, 1, 2);

        // Redirect with skip 3
        cyc(1, 2'd3, 0, 32'd0, 3'd0);
        lit("flush3", 4'd0, 32'h0, 0, 0, 2);
        idle();
        cyc(0, 2'd0, 1, 32'hDDCCBBAA, 3'd0);
        lit("skip3", 4'd1, 32'h000000DD, 0, 0, 3);
        idle();
        lit("skip3_req", 4'd1, 32'h000000DD, 1, 0, 3);

        // Flush with no ack -> stale, returning data dropped
        cyc(1, 2'd2, 0, 32'd0, 3'd0);
        lit("stale", 4'd0, 32'h0, 1, 0, 3);
        cyc(0, 2'd0, 1, 32'hFFFFFFFF, 3'd0);
        lit("stale_drop", 4'd0, 32'h0, 0, 0, 3);

        // Build queue 01..06 using the retained skip of 2
        wait_req();
        cyc(0, 2'd0, 1, 32'h0201EEFF, 3'd0);
        lit("skip2", 4'd2, 32'h00000201, 0, 0, 4);
        wait_req();
        cyc(0, 2'd0, 1, 32'h06050403, 3'd0);
        lit("q6", 4'd6, 32'h04030201, 0, 0, 5);
        cyc(0, 2'd0, 0, 32'd0, 3'd3);
        lit("cons3", 4'd3, 32'h00060504, 1, 0, 5);
        cyc(0, 2'd0, 1, 32'h0A090807, 3'd0);
        lit("fill7", 4'd7, 32'h07060504, 0, 0, 6);
        cyc(0, 2'd0, 0, 32'd0, 3'd4);
        lit("cons4", 4'd3, 32'h000A0908, 1, 0, 6);
        cyc(0, 2'd0, 1, 32'h0E0D0C0B, 3'd2);
        lit("cons_ack", 4'd5, 32'h0D0C0B0A, 0, 0, 7);

        // Flush and ack together -> straight to IDLE
        cyc(0, 2'd0, 0, 32'd0, 3'd1);
        lit("cons1", 4'd4, 32'h0E0D0C0B, 1, 0, 7);
        cyc(1, 2'd2, 1, 32'h55555555, 3'd0);
        lit("flush_ack", 4'd0, 32'h0, 0, 0, 7);
        idle();
        lit("flush_ack_req", 4'd0, 32'h0, 1, 0, 7);
        cyc(0, 2'd0, 1, 32'hBBAA9988, 3'd0);
        lit("fill_skip2", 4'd2, 32'h0000BBAA, 0, 0, 8);

        // Over-consume
        cyc(0, 2'd0, 0, 32'd0, 3'd3);
        lit("overcons", 4'd2, 32'h0000BBAA, 1, 1, 8);
        cyc(1, 2'd0, 0, 32'd0, 3'd0);
        lit("err_clr", 4'd0, 32'h0, 1, 0, 8);
        cyc(0, 2'd0, 1, 32'h12345678, 3'd0);
        lit("stale_drop2", 4'd0, 32'h0, 0, 0, 8);

        // Reset mid-fetch with a simultaneous ack
        wait_req();
        cyc(0, 2'd0, 0, 32'd0, 3'd1);
        lit("err_empty", 4'd0, 32'h0, 1, 1, 8);
        reset_h = 1; bus.ib_ack_h = 1; bus.mem_data_h = 32'hCAFEF00D;
        @(posedge b_clk_l);
        #1;
        reset_h = 0; bus.ib_ack_h = 0; bus.mem_data_h = 0;
        lit("reset_mid", 4'd0, 32'h0, 0, 0, 8);
        idle(); idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
